// File: rtl/gon_apb_pkg.sv
// Shared types and constants for the APB master arbiter.
package gon_apb_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = APB_DATA_W / 8;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_mst_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] addr;
    logic                  write;
    logic [APB_DATA_W-1:0] wdata;
    logic [APB_STRB_W-1:0] strb;
    logic [2:0]            prot;
  } apb_req_t;

endpackage

// File: rtl/gon_apb_master_arb_if.sv
// APB4 pin bundle between the arbitrated master and a completer.
interface gon_apb_master_arb_if;
  import gon_apb_pkg::*;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [APB_DATA_W-1:0] paddr;
  logic [APB_DATA_W-1:0] pwdata;
  logic [APB_STRB_W-1:0] pstrb;
  logic [2:0]            pprot;
  logic                  pready;
  logic                  pslverr;
  logic [APB_DATA_W-1:0] prdata;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  pready, pslverr, prdata
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output pready, pslverr, prdata
  );

endinterface

// File: rtl/gon_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module gon_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    logic             found;
    grant    = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/gon_apb_master_arb.sv
// Round-robin arbiter sharing one APB4 master port, with SETUP/ACCESS sequencing and PREADY timeout.
module gon_apb_master_arb
  import gon_apb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                          pclk,
  input  logic                          presetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*APB_DATA_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*APB_DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*APB_STRB_W-1:0] req_strb,
  input  logic [NUM_REQ*3-1:0]          req_prot,
  output logic                          rsp_valid,
  output logic [ID_W-1:0]               rsp_id,
  output logic [APB_DATA_W-1:0]         rsp_rdata,
  output logic                          rsp_slverr,
  output logic                          rsp_timeout,
  output logic                          apbactive,
  gon_apb_master_arb_if.master          apb
);

  localparam int TCNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  apb_mst_state_e        state_reg, state_next;
  apb_req_t              req_vec [NUM_REQ];
  apb_req_t              req_reg;
  logic [ID_W-1:0]       id_reg;
  logic [ID_W-1:0]       rr_ptr_reg;
  logic [TCNT_W-1:0]     tcnt_reg;
  logic                  rsp_valid_reg;
  logic [ID_W-1:0]       rsp_id_reg;
  logic [APB_DATA_W-1:0] rsp_rdata_reg;
  logic                  rsp_slverr_reg;
  logic                  rsp_timeout_reg;

  logic [NUM_REQ-1:0]    arb_grant;
  logic [ID_W-1:0]       arb_idx;
  logic                  accept;
  logic                  access_done;
  logic                  timeout_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_vec[gi] = '{
        addr:  req_addr[APB_DATA_W*gi +: APB_DATA_W],
        write: req_write[gi],
        wdata: req_wdata[APB_DATA_W*gi +: APB_DATA_W],
        strb:  req_strb[APB_STRB_W*gi +: APB_STRB_W],
        prot:  req_prot[3*gi +: 3]
      };
    end
  endgenerate

  gon_rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_reg),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_reg <= APB_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    req_ready   = '0;
    accept      = 1'b0;
    access_done = 1'b0;
    timeout_hit = 1'b0;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
    apb.paddr   = '0;
    apb.pwdata  = '0;
    apb.pstrb   = '0;
    apb.pprot   = '0;
    case (state_reg)
      APB_IDLE: begin
        // Ready is held low while reset is asserted so nothing looks accepted.
        if (presetn) begin
          req_ready = arb_grant;
        end
        if (presetn && (|req_valid)) begin
          accept     = 1'b1;
          state_next = APB_SETUP;
        end
      end
      APB_SETUP: begin
        apb.psel   = 1'b1;
        state_next = APB_ACCESS;
      end
      APB_ACCESS: begin
        apb.psel    = 1'b1;
        apb.penable = 1'b1;
        if (apb.pready) begin
          access_done = 1'b1;
          state_next  = APB_IDLE;
        end else if ((TIMEOUT_CYC != 0) && (tcnt_reg == TCNT_LAST)) begin
          timeout_hit = 1'b1;
          state_next  = APB_IDLE;
        end
      end
      default: begin
        state_next = APB_IDLE;
      end
    endcase
    if (state_reg != APB_IDLE) begin
      apb.pwrite = req_reg.write;
      apb.paddr  = req_reg.addr;
      apb.pwdata = req_reg.wdata;
      apb.pstrb  = req_reg.write ? req_reg.strb : '0;
      apb.pprot  = req_reg.prot;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      req_reg         <= '0;
      id_reg          <= '0;
      rr_ptr_reg      <= '0;
      tcnt_reg        <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_id_reg      <= '0;
      rsp_rdata_reg   <= '0;
      rsp_slverr_reg  <= 1'b0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      rsp_valid_reg   <= 1'b0;
      rsp_id_reg      <= '0;
      rsp_rdata_reg   <= '0;
      rsp_slverr_reg  <= 1'b0;
      rsp_timeout_reg <= 1'b0;
      if (accept) begin
        req_reg    <= req_vec[arb_idx];
        id_reg     <= arb_idx;
        rr_ptr_reg <= (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
      end
      if (state_reg == APB_SETUP) begin
        tcnt_reg <= '0;
      end else if ((state_reg == APB_ACCESS) && !apb.pready) begin
        tcnt_reg <= tcnt_reg + TCNT_W'(1);
      end
      if (access_done) begin
        rsp_valid_reg  <= 1'b1;
        rsp_id_reg     <= id_reg;
        rsp_rdata_reg  <= req_reg.write ? '0 : apb.prdata;
        rsp_slverr_reg <= apb.pslverr;
      end else if (timeout_hit) begin
        rsp_valid_reg   <= 1'b1;
        rsp_id_reg      <= id_reg;
        rsp_slverr_reg  <= 1'b1;
        rsp_timeout_reg <= 1'b1;
      end
    end
  end

  assign rsp_valid   = rsp_valid_reg;
  assign rsp_id      = rsp_id_reg;
  assign rsp_rdata   = rsp_rdata_reg;
  assign rsp_slverr  = rsp_slverr_reg;
  assign rsp_timeout = rsp_timeout_reg;
  assign apbactive   = (state_reg != APB_IDLE);

endmodule

// File: tb/tb_gon_apb_master_arb.sv
// Scoreboard bench for gon_apb_master_arb: directed scenarios plus a response queue checker.
module tb_gon_apb_master_arb;

  localparam logic [31:0] RD_KEY = 32'h5EED_C0DE;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        slverr;
    logic        timeout;
  } exp_t;

  logic         pclk;
  logic         presetn;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_addr;
  logic [3:0]   req_write;
  logic [127:0] req_wdata;
  logic [15:0]  req_strb;
  logic [11:0]  req_prot;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_rdata;
  logic         rsp_slverr;
  logic         rsp_timeout;
  logic         apbactive;

  gon_apb_master_arb_if apb_bus ();

  gon_apb_master_arb #(
    .NUM_REQ     (4),
    .ID_W        (2),
    .TIMEOUT_CYC (16)
  ) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_write   (req_write),
    .req_wdata   (req_wdata),
    .req_strb    (req_strb),
    .req_prot    (req_prot),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_rdata   (rsp_rdata),
    .rsp_slverr  (rsp_slverr),
    .rsp_timeout (rsp_timeout),
    .apbactive   (apbactive),
    .apb         (apb_bus)
  );

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  int   model_ptr = 0;

  // Completer model: answers after wait_states ACCESS cycles, never when hang is set.
  int   acc_cnt = 0;
  int   wait_states = 0;
  bit   hang = 1'b0;
  bit   err = 1'b0;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(posedge pclk) begin
    if (apb_bus.psel && apb_bus.penable && !apb_bus.pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  assign apb_bus.pready  = apb_bus.psel && apb_bus.penable && !hang && (acc_cnt >= wait_states);
  assign apb_bus.pslverr = apb_bus.pready && err;
  assign apb_bus.prdata  = apb_bus.paddr ^ RD_KEY;

  // Accept monitor: checks the grant against a reference round-robin and queues the expected response.
  always @(negedge pclk) begin
    int         w;
    logic [3:0] exp_g;
    exp_t       e;
    if (presetn === 1'b1 && req_ready !== 4'b0000) begin
      w = -1;
      for (int k = 0; k < 4; k++) begin
        if (w < 0 && req_valid[(model_ptr + k) % 4]) w = (model_ptr + k) % 4;
      end
      exp_g = (w >= 0) ? (4'b0001 << w) : 4'b0000;
      total++;
      if (req_ready !== exp_g) begin
        bad++;
        $display("FAIL grant: req_ready=%b expected=%b", req_ready, exp_g);
      end
      if (w >= 0) begin
        e.id      = w;
        e.timeout = hang;
        e.slverr  = hang | err;
        e.rdata   = (req_write[w] || hang) ? 32'h0 : (req_addr[32*w +: 32] ^ RD_KEY);
        sb.push_back(e);
        model_ptr = (w + 1) % 4;
        $display("accept id=%0d addr=%h write=%0d", w, req_addr[32*w +: 32], req_write[w]);
      end
    end
  end

  // Response monitor: pops the scoreboard on every completion pulse.
  always @(negedge pclk) begin
    exp_t e;
    if (rsp_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected: id=%0d rdata=%h (no response expected)", rsp_id, rsp_rdata);
      end else begin
        e = sb.pop_front();
        if (rsp_id !== 2'(e.id) || rsp_rdata !== e.rdata ||
            rsp_slverr !== e.slverr || rsp_timeout !== e.timeout) begin
          bad++;
          $display("FAIL rsp: got id=%0d rdata=%h err=%b tmo=%b expected id=%0d rdata=%h err=%b tmo=%b",
                   rsp_id, rsp_rdata, rsp_slverr, rsp_timeout, e.id, e.rdata, e.slverr, e.timeout);
        end else begin
          $display("rsp id=%0d rdata=%h err=%b tmo=%b", rsp_id, rsp_rdata, rsp_slverr, rsp_timeout);
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] addr, input logic wr,
                         input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot);
    req_addr[32*i +: 32] = addr;
    req_write[i]         = wr;
    req_wdata[32*i +: 32] = wdata;
    req_strb[4*i +: 4]   = strb;
    req_prot[3*i +: 3]   = prot;
    req_valid[i]         = 1'b1;
  endtask

  task automatic test_reset();
    presetn   = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_write = '0;
    req_wdata = '0;
    req_strb  = '0;
    req_prot  = '0;
    #3;
    total++;
    if ({apb_bus.psel, apb_bus.penable, apbactive, rsp_valid} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ctrl: psel/penable/apbactive/rsp_valid=%b expected 0000",
               {apb_bus.psel, apb_bus.penable, apbactive, rsp_valid});
    end
    total++;
    if (apb_bus.paddr !== 32'h0 || apb_bus.pstrb !== 4'h0 || req_ready !== 4'h0) begin
      bad++;
      $display("FAIL reset_data: paddr=%h pstrb=%h req_ready=%b expected 0",
               apb_bus.paddr, apb_bus.pstrb, req_ready);
    end
    repeat (2) @(posedge pclk);
    #1 presetn = 1'b1;
    model_ptr = 0;
  endtask

  task automatic test_single_read();
    hang = 1'b0; err = 1'b0; wait_states = 0;
    @(posedge pclk); #1;
    set_req(0, 32'h0000_1000, 1'b0, 32'h0, 4'h0, 3'b000);
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL single_ready: req_ready=%b expected 0001", req_ready);
    end
    @(posedge pclk); #1;
    req_valid[0] = 1'b0;
    total++;
    if (apb_bus.psel !== 1'b1 || apb_bus.penable !== 1'b0 || apb_bus.paddr !== 32'h1000 || apb_bus.pwrite !== 1'b0) begin
      bad++;
      $display("FAIL single_setup: psel=%b penable=%b paddr=%h pwrite=%b expected 1 0 00001000 0",
               apb_bus.psel, apb_bus.penable, apb_bus.paddr, apb_bus.pwrite);
    end
    @(posedge pclk); #1;
    total++;
    if (apb_bus.psel !== 1'b1 || apb_bus.penable !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_access: psel=%b penable=%b rsp_valid=%b expected 1 1 0",
               apb_bus.psel, apb_bus.penable, rsp_valid);
    end
    @(posedge pclk); #1;
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_rdata !== (32'h1000 ^ RD_KEY) || apb_bus.psel !== 1'b0) begin
      bad++;
      $display("FAIL single_rsp: rsp_valid=%b id=%0d rdata=%h psel=%b expected 1 0 %h 0",
               rsp_valid, rsp_id, rsp_rdata, apb_bus.psel, 32'h1000 ^ RD_KEY);
    end
  endtask

  task automatic test_round_robin();
    int         grants[4];
    int         rsp_cyc[$];
    int         rsp_ids[$];
    int         cyc;
    logic [3:0] rr;
    hang = 1'b0; err = 1'b0; wait_states = 0;
    @(posedge pclk); #1;
    for (int i = 0; i < 4; i++) begin
      set_req(i, 32'h0000_8000 + 32'h100 * (i + 1), 1'b0, 32'h0, 4'hF, 3'(i));
      grants[i] = 0;
    end
    cyc = 0;
    while (rsp_ids.size() < 8 && cyc < 60) begin
      @(negedge pclk);
      rr = req_ready;
      if (rsp_valid === 1'b1) begin
        rsp_cyc.push_back(cyc);
        rsp_ids.push_back(int'(rsp_id));
      end
      @(posedge pclk); #1;
      cyc++;
      for (int i = 0; i < 4; i++) begin
        if (rr[i]) begin
          grants[i]++;
          if (grants[i] == 2) req_valid[i] = 1'b0;
        end
      end
    end
    total++;
    if (rsp_ids.size() != 8) begin
      bad++;
      $display("FAIL rr_count: responses=%0d expected 8", rsp_ids.size());
    end else begin
      // Pointer sits at 1 after the single read from requester 0.
      total++;
      if (rsp_ids[0] != 1) begin
        bad++;
        $display("FAIL rr_first: id=%0d expected 1", rsp_ids[0]);
      end
      for (int k = 1; k < 8; k++) begin
        total++;
        if (rsp_ids[k] != (rsp_ids[k-1] + 1) % 4 || rsp_cyc[k] - rsp_cyc[k-1] != 3) begin
          bad++;
          $display("FAIL rr_seq[%0d]: id=%0d gap=%0d expected id=%0d gap=3",
                   k, rsp_ids[k], rsp_cyc[k] - rsp_cyc[k-1], (rsp_ids[k-1] + 1) % 4);
        end
      end
    end
    req_valid = '0;
    repeat (2) @(posedge pclk);
  endtask

  task automatic test_write_wait();
    hang = 1'b0; err = 1'b0; wait_states = 5;
    @(posedge pclk); #1;
    set_req(2, 32'h2000_0040, 1'b1, 32'hA5A5_5A5A, 4'b0110, 3'b010);
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL write_ready: req_ready=%b expected 0100", req_ready);
    end
    @(posedge pclk); #1;
    req_valid[2] = 1'b0;
    total++;
    if (apb_bus.psel !== 1'b1 || apb_bus.penable !== 1'b0 || apb_bus.pwrite !== 1'b1 || apb_bus.pprot !== 3'b010) begin
      bad++;
      $display("FAIL write_setup: psel=%b penable=%b pwrite=%b pprot=%b expected 1 0 1 010",
               apb_bus.psel, apb_bus.penable, apb_bus.pwrite, apb_bus.pprot);
    end
    for (int c = 2; c <= 7; c++) begin
      @(posedge pclk); #1;
      total++;
      if (apb_bus.psel !== 1'b1 || apb_bus.penable !== 1'b1 || apbactive !== 1'b1 || rsp_valid !== 1'b0 ||
          apb_bus.paddr !== 32'h2000_0040 || apb_bus.pwdata !== 32'hA5A5_5A5A || apb_bus.pstrb !== 4'b0110) begin
        bad++;
        $display("FAIL write_access T+%0d: psel=%b pen=%b act=%b rsp=%b paddr=%h pwdata=%h pstrb=%b expected 1 1 1 0 20000040 a5a55a5a 0110",
                 c, apb_bus.psel, apb_bus.penable, apbactive, rsp_valid, apb_bus.paddr, apb_bus.pwdata, apb_bus.pstrb);
      end
    end
    @(posedge pclk); #1;
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_rdata !== 32'h0) begin
      bad++;
      $display("FAIL write_rsp T+8: rsp_valid=%b id=%0d rdata=%h expected 1 2 00000000",
               rsp_valid, rsp_id, rsp_rdata);
    end
    wait_states = 0;
  endtask

  task automatic test_read_slverr();
    hang = 1'b0; err = 1'b1; wait_states = 0;
    @(posedge pclk); #1;
    set_req(1, 32'h0000_0300, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'b001);
    @(posedge pclk); #1;
    req_valid[1] = 1'b0;
    total++;
    if (apb_bus.pstrb !== 4'h0 || apb_bus.pwrite !== 1'b0) begin
      bad++;
      $display("FAIL read_strb: pstrb=%b pwrite=%b expected 0000 0", apb_bus.pstrb, apb_bus.pwrite);
    end
    repeat (2) @(posedge pclk);
    #1;
    total++;
    if (rsp_valid !== 1'b1 || rsp_slverr !== 1'b1 || rsp_timeout !== 1'b0) begin
      bad++;
      $display("FAIL read_slverr: rsp_valid=%b slverr=%b timeout=%b expected 1 1 0",
               rsp_valid, rsp_slverr, rsp_timeout);
    end
    err = 1'b0;
  endtask

  task automatic test_timeout();
    int seen;
    hang = 1'b1; err = 1'b0; wait_states = 0;
    @(posedge pclk); #1;
    set_req(3, 32'h0000_0400, 1'b0, 32'h0, 4'h0, 3'b000);
    @(posedge pclk); #1;
    req_valid[3] = 1'b0;
    for (int c = 2; c <= 17; c++) begin
      @(posedge pclk); #1;
      if (c == 17) begin
        total++;
        if (apb_bus.psel !== 1'b1 || apb_bus.penable !== 1'b1) begin
          bad++;
          $display("FAIL tmo_last_access: psel=%b penable=%b expected 1 1", apb_bus.psel, apb_bus.penable);
        end
      end
    end
    @(posedge pclk); #1;
    total++;
    if (apb_bus.psel !== 1'b0 || rsp_valid !== 1'b1 || rsp_slverr !== 1'b1 ||
        rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0 || rsp_id !== 2'd3) begin
      bad++;
      $display("FAIL tmo_rsp: psel=%b rsp_valid=%b slverr=%b timeout=%b rdata=%h id=%0d expected 0 1 1 1 0 3",
               apb_bus.psel, rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata, rsp_id);
    end
    hang = 1'b0; wait_states = 1;
    set_req(0, 32'h0000_0500, 1'b1, 32'h1234_5678, 4'hF, 3'b000);
    @(posedge pclk); #1;
    req_valid[0] = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge pclk);
      if (rsp_valid === 1'b1) seen = 1;
    end
    total++;
    if (seen != 1) begin
      bad++;
      $display("FAIL tmo_next: rsp_seen=%0d expected 1", seen);
    end
    wait_states = 0;
    @(posedge pclk);
  endtask

  task automatic test_reset_mid();
    int         nrsp;
    int         cyc;
    logic [3:0] rr;
    hang = 1'b0; err = 1'b0; wait_states = 10;
    @(posedge pclk); #1;
    set_req(1, 32'h0000_0600, 1'b0, 32'h0, 4'h0, 3'b000);
    @(posedge pclk); #1;
    req_valid[1] = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    presetn = 1'b0;
    sb.delete();
    model_ptr = 0;
    #1;
    total++;
    if ({apb_bus.psel, apb_bus.penable, apbactive} !== 3'b000) begin
      bad++;
      $display("FAIL rstmid_immediate: psel/penable/apbactive=%b expected 000",
               {apb_bus.psel, apb_bus.penable, apbactive});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge pclk);
      total++;
      if (rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL rstmid_norsp: rsp_valid=%b expected 0", rsp_valid);
      end
    end
    @(posedge pclk); #1;
    presetn = 1'b1;
    wait_states = 0;
    set_req(1, 32'h0000_0710, 1'b1, 32'h0000_0011, 4'h3, 3'b000);
    set_req(0, 32'h0000_0700, 1'b1, 32'h0000_0022, 4'h3, 3'b000);
    set_req(2, 32'h0000_0720, 1'b0, 32'h0, 4'h0, 3'b000);
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL rstmid_first: req_ready=%b expected 0001", req_ready);
    end
    nrsp = 0;
    cyc = 0;
    while (nrsp < 3 && cyc < 40) begin
      @(negedge pclk);
      rr = req_ready;
      if (rsp_valid === 1'b1) nrsp++;
      @(posedge pclk); #1;
      cyc++;
      req_valid = req_valid & ~rr;
    end
    total++;
    if (nrsp != 3) begin
      bad++;
      $display("FAIL rstmid_drain: responses=%0d expected 3", nrsp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_wait();
    test_read_slverr();
    test_timeout();
    test_reset_mid();
    repeat (3) @(posedge pclk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: pending=%0d expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
